// File: rtl/vga_timing_gen.sv
// vga_timing_gen: runtime-reprogrammable VGA/DVI raster timing generator.
// Shadowed timing fields are copied to the active set only at a frame end.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-low reset
//   cfg_we       write cfg_data into shadow field cfg_addr
//   cfg_addr     0 WIDTH 1 HFP 2 HSYNC 3 HBP 4 HEIGHT 5 VFP 6 VSYNC 7 VBP
//                (8 irq_line with VGA_LINE_IRQ_EN)
//   cfg_data     field value
//   cfg_commit   arms a shadow-to-active copy at the next frame end
//   cfg_pending  commit armed, not yet applied
//   cfg_err      sticky, last commit was rejected
//   x, y         presented pixel coordinate
//   de, hblank, vblank, hsync, vsync, line_start, frame_start
//                raster flags, DELAY cycles behind x/y
//   irq          line interrupt (only with VGA_LINE_IRQ_EN)
//
// Optional feature macro: VGA_LINE_IRQ_EN (adds irq port, irq_line field).

module vga_timing_gen #(
  parameter int CW     = 12,
  parameter int WIDTH  = 800,
  parameter int HFP    = 40,
  parameter int HSYNC  = 128,
  parameter int HBP    = 88,
  parameter int HEIGHT = 600,
  parameter int VFP    = 1,
  parameter int VSYNC  = 4,
  parameter int VBP    = 23,
  parameter int HPOL   = 1,
  parameter int VPOL   = 1,
  parameter int DELAY  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
`ifdef VGA_LINE_IRQ_EN
  input  logic [3:0]    cfg_addr,
`else
  input  logic [2:0]    cfg_addr,
`endif
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_pending,
  output logic          cfg_err,
`ifdef VGA_LINE_IRQ_EN
  output logic          irq,
`endif
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

`ifdef VGA_LINE_IRQ_EN
  localparam int AW    = 4;
  localparam int NFLD  = 9;
  localparam int NFL   = 8;
  localparam int F_IRQ = 8;
  localparam int B_IRQ = 7;
`else
  localparam int AW    = 3;
  localparam int NFLD  = 8;
  localparam int NFL   = 7;
`endif

  localparam int F_W   = 0;
  localparam int F_HFP = 1;
  localparam int F_HS  = 2;
  localparam int F_HBP = 3;
  localparam int F_H   = 4;
  localparam int F_VFP = 5;
  localparam int F_VS  = 6;
  localparam int F_VBP = 7;

  localparam int B_DE  = 0;
  localparam int B_HB  = 1;
  localparam int B_VB  = 2;
  localparam int B_HS  = 3;
  localparam int B_VS  = 4;
  localparam int B_LS  = 5;
  localparam int B_FS  = 6;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic LP_HP = (HPOL != 0);
  localparam logic LP_VP = (VPOL != 0);

  function automatic logic [NFL-1:0] f_idle();
    logic [NFL-1:0] v;
    v       = '0;
    v[B_HB] = 1'b1;
    v[B_VB] = 1'b1;
    v[B_HS] = !LP_HP;
    v[B_VS] = !LP_VP;
    return v;
  endfunction

  localparam logic [NFL-1:0] LP_IDLE = f_idle();

  function automatic logic [CW-1:0] f_dflt(input int idx);
    logic [CW-1:0] v;
    case (idx)
      F_W:     v = CW'(WIDTH);
      F_HFP:   v = CW'(HFP);
      F_HS:    v = CW'(HSYNC);
      F_HBP:   v = CW'(HBP);
      F_H:     v = CW'(HEIGHT);
      F_VFP:   v = CW'(VFP);
      F_VS:    v = CW'(VSYNC);
      F_VBP:   v = CW'(VBP);
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [CW-1:0]  r_act [NFLD];
  logic [CW-1:0]  r_shd [NFLD];
  logic [CW-1:0]  w_eff [NFLD];
  logic           r_pending;
  logic           r_err;
  logic [CW-1:0]  r_cx;
  logic [CW-1:0]  r_cy;
  logic [CW-1:0]  r_x;
  logic [CW-1:0]  r_y;
  logic [NFL-1:0] r_f0;
  logic [NFL-1:0] w_flg;
  logic [NFL-1:0] w_fout;

  logic [CW-1:0]  w_fullx;
  logic [CW-1:0]  w_fully;
  logic [CW-1:0]  w_effx;
  logic [CW-1:0]  w_effy;
  logic [CW-1:0]  w_hs_lo;
  logic [CW-1:0]  w_hs_hi;
  logic [CW-1:0]  w_vs_lo;
  logic [CW-1:0]  w_vs_hi;
  logic           w_last;
  logic           w_commit;
  logic           w_shd_ok;
  logic           w_load;
  logic           w_x_wrap;
  logic           w_y_wrap;

  // Totals of the timing currently on screen.
  assign w_fullx = r_act[F_W] + r_act[F_HFP]
                 + r_act[F_HS] + r_act[F_HBP];
  assign w_fully = r_act[F_H] + r_act[F_VFP]
                 + r_act[F_VS] + r_act[F_VBP];

  // The last pixel of the frame is on screen this cycle.
  assign w_last   = (r_x == w_fullx - ONE)
                 && (r_y == w_fully - ONE);
  assign w_commit = w_last && r_pending;
  assign w_shd_ok = (r_shd[F_W] != '0) && (r_shd[F_H] != '0)
                 && (r_shd[F_HS] != '0) && (r_shd[F_VS] != '0);
  assign w_load   = w_commit && w_shd_ok;

  // Timing that governs the pixel being registered at this edge:
  // on a successful commit the new set already applies to (0,0).
  always_comb begin
    for (int k = 0; k < NFLD; k++) begin
      w_eff[k] = w_load ? r_shd[k] : r_act[k];
    end
  end

  assign w_effx  = w_eff[F_W] + w_eff[F_HFP]
                 + w_eff[F_HS] + w_eff[F_HBP];
  assign w_effy  = w_eff[F_H] + w_eff[F_VFP]
                 + w_eff[F_VS] + w_eff[F_VBP];
  assign w_hs_lo = w_eff[F_W] + w_eff[F_HFP];
  assign w_hs_hi = w_hs_lo + w_eff[F_HS];
  assign w_vs_lo = w_eff[F_H] + w_eff[F_VFP];
  assign w_vs_hi = w_vs_lo + w_eff[F_VS];

  assign w_x_wrap = (r_cx == w_effx - ONE);
  assign w_y_wrap = (r_cy == w_effy - ONE);

  // Flags for the pixel (r_cx, r_cy) about to be presented.
  always_comb begin
    w_flg       = '0;
    w_flg[B_DE] = (r_cx < w_eff[F_W]) && (r_cy < w_eff[F_H]);
    w_flg[B_HB] = (r_cx >= w_eff[F_W]);
    w_flg[B_VB] = (r_cy >= w_eff[F_H]);
    w_flg[B_HS] = ((r_cx >= w_hs_lo) && (r_cx < w_hs_hi))
                ? LP_HP : !LP_HP;
    w_flg[B_VS] = ((r_cy >= w_vs_lo) && (r_cy < w_vs_hi))
                ? LP_VP : !LP_VP;
    w_flg[B_LS] = (r_cx == '0);
    w_flg[B_FS] = (r_cx == '0) && (r_cy == '0);
`ifdef VGA_LINE_IRQ_EN
    w_flg[B_IRQ] = (r_cx == '0)
                && (r_cy == w_eff[F_IRQ])
                && (w_eff[F_IRQ] < w_effy);
`endif
  end

  // Shadow / active register file and commit bookkeeping.
  // The active copy reads the pre-write shadow on a same-cycle write.
  always_ff @(posedge clk) begin : p_cfg
    if (!reset) begin
      for (int k = 0; k < NFLD; k++) begin
        r_act[k] <= f_dflt(k);
        r_shd[k] <= f_dflt(k);
      end
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      for (int k = 0; k < NFLD; k++) begin
        if (w_load) begin
          r_act[k] <= r_shd[k];
        end
        if (cfg_we && (cfg_addr == AW'(k))) begin
          r_shd[k] <= cfg_data;
        end
      end
      if (w_commit) begin
        r_err     <= !w_shd_ok;
        r_pending <= cfg_commit;
      end else if (cfg_commit) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Raster counter runs one pixel ahead of the presented x/y.
  always_ff @(posedge clk) begin : p_ras
    if (!reset) begin
      r_cx <= '0;
      r_cy <= '0;
      r_x  <= '0;
      r_y  <= '0;
      r_f0 <= LP_IDLE;
    end else begin
      r_x  <= r_cx;
      r_y  <= r_cy;
      r_f0 <= w_flg;
      if (w_x_wrap) begin
        r_cx <= '0;
        r_cy <= w_y_wrap ? '0 : r_cy + ONE;
      end else begin
        r_cx <= r_cx + ONE;
      end
    end
  end

  generate
    if (DELAY == 0) begin : g_nodly
      assign w_fout = r_f0;
    end else begin : g_dly
      logic [NFL-1:0] r_dly [DELAY];
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < DELAY; k++) begin
            r_dly[k] <= LP_IDLE;
          end
        end else begin
          r_dly[0] <= r_f0;
          for (int k = 1; k < DELAY; k++) begin
            r_dly[k] <= r_dly[k-1];
          end
        end
      end
      assign w_fout = r_dly[DELAY-1];
    end
  endgenerate

  assign x           = r_x;
  assign y           = r_y;
  assign cfg_pending = r_pending;
  assign cfg_err     = r_err;
  assign de          = w_fout[B_DE];
  assign hblank      = w_fout[B_HB];
  assign vblank      = w_fout[B_VB];
  assign hsync       = w_fout[B_HS];
  assign vsync       = w_fout[B_VS];
  assign line_start  = w_fout[B_LS];
  assign frame_start = w_fout[B_FS];
`ifdef VGA_LINE_IRQ_EN
  assign irq         = w_fout[B_IRQ];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Three instances (small/DELAY=0, small/DELAY=3/low pol, full defaults).

module tb_vga_timing_gen;

  localparam int CW = 12;
  localparam int NI = 3;
`ifdef VGA_LINE_IRQ_EN
  localparam int AW   = 4;
  localparam int NFLD = 9;
`else
  localparam int AW   = 3;
  localparam int NFLD = 8;
`endif

  localparam int DS [9] = '{10, 2, 3, 2, 5, 1, 2, 1, 0};
  localparam int DB [9] = '{800, 40, 128, 88, 600, 1, 4, 23, 0};

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [7:0]    f;
    logic          p;
    logic          e;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_commit = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;

  logic [CW-1:0] ox [NI];
  logic [CW-1:0] oy [NI];
  logic opend [NI];
  logic oerr [NI];
  logic ode [NI];
  logic ohb [NI];
  logic ovb [NI];
  logic ohs [NI];
  logic ovs [NI];
  logic ols [NI];
  logic ofs [NI];
  logic oirq [NI];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam bit BIG = (g == 2);
    vga_timing_gen #(
      .CW(CW),
      .WIDTH(BIG ? 800 : 10),
      .HFP(BIG ? 40 : 2),
      .HSYNC(BIG ? 128 : 3),
      .HBP(BIG ? 88 : 2),
      .HEIGHT(BIG ? 600 : 5),
      .VFP(1),
      .VSYNC(BIG ? 4 : 2),
      .VBP(BIG ? 23 : 1),
      .HPOL(g == 1 ? 0 : 1),
      .VPOL(g == 1 ? 0 : 1),
      .DELAY(g == 1 ? 3 : 0)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .cfg_we(cfg_we),
      .cfg_addr(cfg_addr),
      .cfg_data(cfg_data),
      .cfg_commit(cfg_commit),
      .cfg_pending(opend[g]),
      .cfg_err(oerr[g]),
`ifdef VGA_LINE_IRQ_EN
      .irq(oirq[g]),
`endif
      .x(ox[g]),
      .y(oy[g]),
      .de(ode[g]),
      .hblank(ohb[g]),
      .vblank(ovb[g]),
      .hsync(ohs[g]),
      .vsync(ovs[g]),
      .line_start(ols[g]),
      .frame_start(ofs[g])
    );
`ifndef VGA_LINE_IRQ_EN
    assign oirq[g] = 1'b0;
`endif
  end

  // ---------------- reference model ----------------
  int act [NI][9];
  int shd [NI][9];
  bit pend [NI];
  bit err [NI];
  bit pres [NI];
  int px [NI];
  int py [NI];
  logic [7:0] hst [NI][8];

  obs_t q0 [$];
  obs_t q1 [$];
  obs_t q2 [$];

  function automatic int dv(int i, int k);
    return (i == 2) ? DB[k] : DS[k];
  endfunction

  function automatic bit hp(int i);
    return i != 1;
  endfunction

  function automatic int dly(int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic int fullx(int i);
    return act[i][0] + act[i][1] + act[i][2] + act[i][3];
  endfunction

  function automatic int fully(int i);
    return act[i][4] + act[i][5] + act[i][6] + act[i][7];
  endfunction

  // bit order: irq fs ls vs hs vb hb de
  function automatic logic [7:0] idle(int i);
    return {3'b000, !hp(i), !hp(i), 3'b110};
  endfunction

  function automatic logic [7:0] mflags(int i, int cx, int cy);
    logic [7:0] f;
    int w = act[i][0];
    int hl = w + act[i][1];
    int hh = hl + act[i][2];
    int h = act[i][4];
    int vl = h + act[i][5];
    int vh = vl + act[i][6];
    f = '0;
    f[0] = (cx < w) && (cy < h);
    f[1] = (cx >= w);
    f[2] = (cy >= h);
    f[3] = (cx >= hl && cx < hh) ? hp(i) : !hp(i);
    f[4] = (cy >= vl && cy < vh) ? hp(i) : !hp(i);
    f[5] = (cx == 0);
    f[6] = (cx == 0) && (cy == 0);
`ifdef VGA_LINE_IRQ_EN
    f[7] = (cx == 0) && (cy == act[i][8])
        && (act[i][8] < fully(i));
`endif
    return f;
  endfunction

  function automatic void push(int i, obs_t o);
    case (i)
      0: q0.push_back(o);
      1: q1.push_back(o);
      default: q2.push_back(o);
    endcase
  endfunction

  function automatic int qsz(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic obs_t pop(int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void step(int i);
    logic [7:0] fn;
    logic [7:0] fo;
    int fx;
    int fy;
    bit ok;
    int d = dly(i);
    if (!reset) begin
      for (int k = 0; k < 9; k++) begin
        act[i][k] = dv(i, k);
        shd[i][k] = dv(i, k);
      end
      pend[i] = 0;
      err[i] = 0;
      pres[i] = 0;
      px[i] = 0;
      py[i] = 0;
      for (int k = 0; k < 8; k++) hst[i][k] = idle(i);
      fo = idle(i);
    end else begin
      fx = fullx(i);
      fy = fully(i);
      if (pres[i] && pend[i] && px[i] == fx - 1 && py[i] == fy - 1) begin
        ok = shd[i][0] != 0 && shd[i][4] != 0
          && shd[i][2] != 0 && shd[i][6] != 0;
        if (ok) begin
          for (int k = 0; k < 9; k++) act[i][k] = shd[i][k];
        end
        err[i] = !ok;
        pend[i] = cfg_commit;
      end else if (cfg_commit) begin
        pend[i] = 1;
      end
      if (cfg_we && int'(cfg_addr) < NFLD) begin
        shd[i][int'(cfg_addr)] = int'(cfg_data);
      end
      if (!pres[i]) begin
        pres[i] = 1;
        px[i] = 0;
        py[i] = 0;
      end else if (px[i] == fx - 1) begin
        px[i] = 0;
        py[i] = (py[i] == fy - 1) ? 0 : py[i] + 1;
      end else begin
        px[i] = px[i] + 1;
      end
      fn = mflags(i, px[i], py[i]);
      if (d == 0) begin
        fo = fn;
      end else begin
        fo = hst[i][d-1];
        for (int k = 7; k > 0; k--) hst[i][k] = hst[i][k-1];
        hst[i][0] = fn;
      end
    end
    push(i, {CW'(px[i]), CW'(py[i]), fo, pend[i], err[i]});
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) step(i);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    obs_t got;
    obs_t exp;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (qsz(i) > 0) begin
          exp = pop(i);
          got.x = ox[i];
          got.y = oy[i];
          got.f = {oirq[i], ofs[i], ols[i], ovs[i],
                   ohs[i], ovb[i], ohb[i], ode[i]};
          got.p = opend[i];
          got.e = oerr[i];
          n_chk++;
          if (got !== exp) begin
            n_fail++;
            $display("FAIL raster dut%0d t=%0t: got x=%0d y=%0d flags=%b pend=%b err=%b, want x=%0d y=%0d flags=%b pend=%b err=%b",
                     i, $time, got.x, got.y, got.f, got.p, got.e,
                     exp.x, exp.y, exp.f, exp.p, exp.e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic wr(int a, int d);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = CW'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  function automatic bit at_cp();
    return pres[0] && pend[0]
        && px[0] == fullx(0) - 1 && py[0] == fully(0) - 1;
  endfunction

  task automatic wait_cp(int lim);
    bit hit = 0;
    for (int n = 0; n < lim; n++) begin
      if (at_cp()) begin
        hit = 1;
        break;
      end
      tick();
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL commit_point: not reached in %0d cycles, want reached", lim);
    end
  endtask

  task automatic wait_xy(int wx, int wy, int lim);
    bit hit = 0;
    for (int n = 0; n < lim; n++) begin
      if (pres[0] && px[0] == wx && py[0] == wy) begin
        hit = 1;
        break;
      end
      tick();
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL pixel_wait: (%0d,%0d) not reached in %0d cycles", wx, wy, lim);
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    run(1200);

    wr(0, 4); wr(1, 1); wr(2, 2); wr(3, 1);
    wr(4, 3); wr(5, 1); wr(6, 1); wr(7, 1);
    commit();
    run(400);

    wr(0, 0);
    commit();
    run(120);
    wr(0, 4);
    commit();
    run(120);

    commit();
    wait_cp(200);
    cfg_we = 1'b1;
    cfg_addr = AW'(0);
    cfg_data = CW'(6);
    cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    run(200);

    repeat (3000) begin
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_addr = AW'($urandom_range(0, NFLD - 1));
      cfg_data = CW'($urandom_range(0, 4));
      cfg_commit = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 399) != 0);
      tick();
    end
    cfg_we = 1'b0;
    cfg_commit = 1'b0;

    reset = 1'b0;
    tick();
    reset = 1'b1;
    run(30);
    wait_xy(2, 1, 400);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    run(400);

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised, runtime-reprogrammable VGA/DVI raster timing generator.
- Produces pixel coordinates, sync, data-enable, blanking and line/frame strobes for the video output path.
- Timing fields are written into shadow registers and take effect only at a frame boundary, so the raster never tears.
- A DELAY parameter skews sync/de/blank outputs behind x/y to match a downstream pixel pipeline.

Parameters:
- CW, 12, counter and config-field width (bits).
- WIDTH, 800, default active pixels per line.
- HFP, 40, default horizontal front porch.
- HSYNC, 128, default hsync width.
- HBP, 88, default horizontal back porch.
- HEIGHT, 600, default active lines.
- VFP, 1, default vertical front porch.
- VSYNC, 4, default vsync width.
- VBP, 23, default vertical back porch.
- HPOL, 1, hsync active level (1 = active-high).
- VPOL, 1, vsync active level.
- DELAY, 0, extra register stages on hsync/vsync/de/hblank/vblank/line_start/frame_start relative to x/y (0..7).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-low reset.
- cfg_we  in  1  write cfg_data into shadow field cfg_addr.
- cfg_addr  in  3  field select: 0 WIDTH, 1 HFP, 2 HSYNC, 3 HBP, 4 HEIGHT, 5 VFP, 6 VSYNC, 7 VBP.
- cfg_data  in  CW  field value.
- cfg_commit  in  1  pulse; arms shadow-to-active copy at next frame end.
- cfg_pending  out  1  commit armed, not yet applied.
- cfg_err  out  1  sticky; last commit was rejected.
- x  out  CW  current column.
- y  out  CW  current row.
- de  out  1  high for active pixels.
- hblank  out  1  high when x >= width.
- vblank  out  1  high when y >= height.
- hsync  out  1  at HPOL level when width+hfp <= x < width+hfp+hsync.
- vsync  out  1  at VPOL level when height+vfp <= y < height+vfp+vsync.
- line_start  out  1  one-cycle pulse when x==0.
- frame_start  out  1  one-cycle pulse when x==0 and y==0.
- irq  out  1  only with VGA_LINE_IRQ_EN; see Optional Feature.

Behaviour:
- Single clock domain. Reset is synchronous and active-low; it is sampled only on the rising clk edge.
- Terms: fullx = width+hfp+hsync+hbp, fully = height+vfp+vsync+vbp, both computed from the active registers.
- Reset (reset low at an edge):
  - Active and shadow registers load the parameter defaults.
  - cfg_pending=0, cfg_err=0, x=y=0, de=0, hblank=vblank=1, hsync=!HPOL, vsync=!VPOL, line_start=frame_start=0, irq=0.
  - The DELAY pipeline flushes to these idle values.
- First edge with reset high presents pixel (0,0): x=0, y=0, line_start=1, frame_start=1. With DELAY=0, de=1 in that same cycle.
- All outputs are registered. With DELAY=0, every flag describes the (x,y) presented in the same cycle. The internal counter runs one pixel ahead.
- Raster advance, per cycle:
  - x advances to x+1.
  - At x==fullx-1: x wraps to 0 and y advances to y+1.
  - At x==fullx-1 and y==fully-1: y wraps to 0.
- DELAY=N: listed flags lag x/y by exactly N cycles. Flag outputs show idle values for N cycles after reset release.
- cfg_we writes the shadow field only. Active timing is unaffected.
- cfg_commit sets cfg_pending.
- Commit point is the cycle presenting the last pixel of a frame (x==fullx-1, y==fully-1) with cfg_pending=1:
  - Validation rule: shadow width, height, hsync and vsync must all be nonzero; porches may be 0.
  - Shadow valid: active <= shadow, cfg_err cleared, next pixel is (0,0) under the new timing.
  - Shadow invalid: active registers unchanged, cfg_err set.
  - In both cases cfg_pending is cleared.
- Same-cycle conflicts:
  - cfg_we at the commit point writes the shadow, but the copy uses the pre-write shadow.
  - cfg_commit at the commit point is not applied there; it arms the next frame end.
- Totals that overflow CW: counters wrap modulo 2^CW. This is the integrator's responsibility; the block does not check it.
- Reset mid-frame: counters return to 0 and the shadow returns to defaults; any pending commit is discarded.

Optional Feature:
- Macro: VGA_LINE_IRQ_EN.
- Defined:
  - cfg_addr widens to 4 bits; address 8 is irq_line (shadowed and committed like the other fields, default 0).
  - irq pulses one cycle, under the DELAY skew, when x==0 and y==irq_line.
  - If irq_line >= fully, no pulse.
- Undefined: irq port absent, cfg_addr is 3 bits, addresses are as listed above.

Test Plan:
- Defaults, DELAY=0, release reset:
  - fullx=1056, fully=628; x wraps 1055->0 with y+1.
  - hsync high for x in 840..967.
  - vsync high for y in 601..604.
  - frame_start every 663168 cycles.
- Program 4/1/2/1, 3/1/1/1, then commit mid-frame:
  - cfg_pending=1 until the end of the current 800x600 frame.
  - Next frame: 8x6 raster, 48 cycles per frame.
  - de high for x 0..3, y 0..2.
  - hsync for x 5..6, vsync at y=4.
- Commit with shadow WIDTH=0 -> cfg_err=1, timing unchanged, cfg_pending=0. Next valid commit -> cfg_err=0.
- cfg_we (addr 0, value 6) and cfg_commit asserted exactly at the commit point -> current commit applies the old shadow. Width 6 takes effect one frame later.
- DELAY=3, small mode -> de/hsync/frame_start lag x/y by exactly 3 cycles. Idle values are shown for the first 3 cycles after reset.
- Reset pulsed low mid-line at (2,1) -> next presented pixel (0,0) with frame_start=1. Timing returns to the defaults.
